// File: rtl/md_pkg.sv
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared encodings and constants for the multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int CNT_W          = 4;

endpackage

`default_nettype wire

// File: rtl/md_scheduler_if.sv
// ============================================================================
// Module   : md_scheduler_if
// Purpose  : EX/ID-stage command and HI/LO result bundle for md_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_scheduler_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        md_in_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, md_in_d,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, md_in_d,
    output busy, stall, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
// Module   : md_arith
// Purpose  : Combinational 32x32 multiply and divide producing {hi, lo}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_arith
  import md_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_op,
  output logic [63:0] o_res,
  output logic        o_div_by_zero
);

  logic        w_is_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_dbz;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_is_signed = (i_op == MD_MULT) || (i_op == MD_DIV);

  // Low 64 bits of the extended product are the exact signed or unsigned result.
  assign w_a_ext = {{32{w_is_signed & i_a[31]}}, i_a};
  assign w_b_ext = {{32{w_is_signed & i_b[31]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed division is done on magnitudes so truncation is always toward zero.
  assign w_a_neg = w_is_signed & i_a[31];
  assign w_b_neg = w_is_signed & i_b[31];
  assign w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;
  assign w_dbz   = (i_b == 32'd0);
  assign w_den   = w_dbz ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_den;
  assign w_r_mag = w_a_mag % w_den;
  assign w_q     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  assign o_res         = i_op[1] ? {w_r, w_q} : w_prod;
  assign o_div_by_zero = i_op[1] & w_dbz;

endmodule

`default_nettype wire

// File: rtl/md_scheduler.sv
// ============================================================================
// Module   : md_scheduler
// Purpose  : Fixed-latency multiply/divide sequencer owning HI/LO and stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  md_scheduler_if.slave  md
);

  localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic             r_dbz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [0:0]       w_state;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_res_hi_nxt;
  logic [31:0]      w_res_lo_nxt;
  logic             w_dbz_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [63:0]      w_arith_res;
  logic             w_arith_dbz;

  md_arith u_arith (
    .i_a           (md.a),
    .i_b           (md.b),
    .i_op          (md.op),
    .o_res         (w_arith_res),
    .o_div_by_zero (w_arith_dbz)
  );

  assign w_state = (r_cnt != '0) ? S_BUSY : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
      r_dbz    <= w_dbz_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    w_dbz_nxt    = r_dbz;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (w_state)
      S_IDLE: begin
        if (md.start) begin
          w_cnt_nxt    = md.op[1] ? c_div_cnt : c_mult_cnt;
          w_res_hi_nxt = w_arith_res[63:32];
          w_res_lo_nxt = w_arith_res[31:0];
          w_dbz_nxt    = w_arith_dbz;
        end else begin
          if (md.mthi) w_hi_nxt = md.a;
          if (md.mtlo) w_lo_nxt = md.a;
        end
      end
      default: begin
        // Commands arriving while busy are dropped; only the countdown advances.
        w_cnt_nxt = r_cnt - 1'b1;
        if ((r_cnt == CNT_W'(1)) && !r_dbz) begin
          w_hi_nxt = r_res_hi;
          w_lo_nxt = r_res_lo;
        end
      end
    endcase
  end

  always_comb begin
    md.busy  = (w_state == S_BUSY);
    md.stall = md.md_in_d & (md.start | (w_state == S_BUSY));
    md.hi    = r_hi;
    md.lo    = r_lo;
  end

endmodule

`default_nettype wire

// File: tb/tb_md_scheduler.sv
// ============================================================================
// Module   : tb_md_scheduler
// Purpose  : Scoreboard bench for md_scheduler with a behavioural HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_scheduler;
  import md_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_scheduler_if mif();

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mif)
  );

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          m_rem   = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  logic [31:0] p_hi    = '0;
  logic [31:0] p_lo    = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    p  = '0;
    case (op)
      2'd0: p = 64'(sx * sy);
      2'd1: p = ux * uy;
      2'd2: if (sy != 0) begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
      default: if (uy != 0) begin
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        p = {r[31:0], q[31:0]};
      end
    endcase
    return p;
  endfunction

  // Architectural effect of one clock edge on the model.
  task automatic model_edge();
    exp_t        e;
    logic [63:0] r;
    if (m_rem == 0) begin
      if (mif.start) begin
        r        = ref_result(mif.op, mif.a, mif.b);
        e.old_hi = m_hi;
        e.old_lo = m_lo;
        e.n      = mif.op[1] ? 10 : 5;
        if (mif.op[1] && mif.b == 32'd0) begin
          e.hi = m_hi;
          e.lo = m_lo;
        end else begin
          e.hi = r[63:32];
          e.lo = r[31:0];
        end
        sb_q.push_back(e);
        m_rem = e.n;
        p_hi  = e.hi;
        p_lo  = e.lo;
      end else begin
        if (mif.mthi) m_hi = mif.a;
        if (mif.mtlo) m_lo = mif.a;
      end
    end else begin
      if (mif.start || mif.mthi || mif.mtlo)
        $display("protocol error: command issued while busy at %0t, expected to be ignored", $time);
      m_rem--;
      if (m_rem == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("busy", 64'(mif.busy), 64'(m_rem != 0));
    chk("stall", 64'(mif.stall), 64'(mif.md_in_d & (mif.start | (m_rem != 0))));
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic md);
    mif.start   = 1'b1;
    mif.op      = op;
    mif.a       = x;
    mif.b       = y;
    mif.md_in_d = md;
    tick();
    mif.start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_md);
    int g = 0;
    while (m_rem != 0 && g < 50) begin
      if (rnd_md) mif.md_in_d = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    if (m_rem != 0) chk("idle_timeout", 64'(m_rem), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: pops one expectation per completed busy period.
  initial begin
    int   run  = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
        run  = 0;
      end else if (mif.busy) begin
        run++;
        if (sb_q.size() > 0) begin
          chk("hold_hi", 64'(mif.hi), 64'(sb_q[0].old_hi));
          chk("hold_lo", 64'(mif.lo), 64'(sb_q[0].old_lo));
        end else begin
          chk("busy_without_op", 64'(sb_q.size()), 64'd1);
        end
        prev = 1'b1;
      end else begin
        if (prev) begin
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("busy_len", 64'(run), 64'(e.n));
            chk("res_hi", 64'(mif.hi), 64'(e.hi));
            chk("res_lo", 64'(mif.lo), 64'(e.lo));
          end else begin
            chk("spurious_done", 64'(sb_q.size()), 64'd1);
          end
        end
        prev = 1'b0;
        run  = 0;
      end
    end
  end

  initial begin
    rst         = 1'b0;
    mif.start   = 1'b0;
    mif.op      = 2'd0;
    mif.a       = '0;
    mif.b       = '0;
    mif.mthi    = 1'b0;
    mif.mtlo    = 1'b0;
    mif.md_in_d = 1'b0;
    repeat (3) tick();
    chk("rst_hi", 64'(mif.hi), 64'd0);
    chk("rst_lo", 64'(mif.lo), 64'd0);
    chk("rst_busy", 64'(mif.busy), 64'd0);
    rst = 1'b1;
    tick();

    // Signed multiply with the ID consumer waiting the whole time.
    issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
    wait_idle(1'b0);
    tick();
    chk("mult_hi", 64'(mif.hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(mif.lo), 64'hFFFFFFEB);
    mif.md_in_d = 1'b0;

    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle(1'b0);
    chk("multu_hi", 64'(mif.hi), 64'h1);
    chk("multu_lo", 64'(mif.lo), 64'hFFFFFFFE);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(1'b0);
    chk("div_hi", 64'(mif.hi), 64'hFFFFFFFF);
    chk("div_lo", 64'(mif.lo), 64'hFFFFFFFD);

    issue(MD_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle(1'b0);
    chk("dbz_hi", 64'(mif.hi), 64'hFFFFFFFF);
    chk("dbz_lo", 64'(mif.lo), 64'hFFFFFFFD);

    mif.a = 32'h12345678; mif.mthi = 1'b1;
    tick();
    mif.mthi = 1'b0;
    chk("mthi", 64'(mif.hi), 64'h12345678);
    mif.a = 32'h9ABCDEF0; mif.mtlo = 1'b1;
    tick();
    mif.mtlo = 1'b0;
    chk("mtlo", 64'(mif.lo), 64'h9ABCDEF0);
    mif.a = 32'h0BADF00D; mif.mthi = 1'b1; mif.mtlo = 1'b1;
    tick();
    mif.mthi = 1'b0; mif.mtlo = 1'b0;
    chk("mt_both_hi", 64'(mif.hi), 64'h0BADF00D);
    chk("mt_both_lo", 64'(mif.lo), 64'h0BADF00D);

    // start wins over a simultaneous mthi.
    mif.mthi = 1'b1;
    issue(MD_MULTU, 32'd3, 32'd4, 1'b0);
    mif.mthi = 1'b0;
    tick();
    mif.a = 32'hDEADBEEF; mif.mthi = 1'b1;
    tick();
    mif.mthi = 1'b0;
    wait_idle(1'b0);
    chk("mthi_busy_hi", 64'(mif.hi), 64'h0);
    chk("mthi_busy_lo", 64'(mif.lo), 64'd12);

    // Asynchronous reset in the middle of a divide.
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    tick();
    sb_q.delete();
    rst   = 1'b0;
    m_rem = 0;
    m_hi  = '0;
    m_lo  = '0;
    #1;
    chk("arst_busy", 64'(mif.busy), 64'd0);
    chk("arst_hi", 64'(mif.hi), 64'd0);
    chk("arst_lo", 64'(mif.lo), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    issue(MD_MULT, 32'd2, 32'd3, 1'b0);
    wait_idle(1'b0);
    chk("post_rst_hi", 64'(mif.hi), 64'd0);
    chk("post_rst_lo", 64'(mif.lo), 64'd6);

    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mif.a       = $urandom;
        mif.mthi    = 1'($urandom_range(0, 3) == 0);
        mif.mtlo    = 1'($urandom_range(0, 3) == 0);
        mif.md_in_d = 1'($urandom_range(0, 1));
        tick();
        mif.mthi = 1'b0;
        mif.mtlo = 1'b0;
        chk("rnd_mt_hi", 64'(mif.hi), 64'(m_hi));
        chk("rnd_mt_lo", 64'(mif.lo), 64'(m_lo));
      end
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
            1'($urandom_range(0, 1)));
      wait_idle(1'b1);
    end

    mif.md_in_d = 1'b0;
    tick();
    tick();
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
